// File: rtl/cv32e40s_rvfi_pkg.sv
// RVFI record types and trace-frame constants shared by the retirement trace
// serializer and its record FIFO.
package cv32e40s_rvfi_pkg;

    typedef struct packed {
        logic       clicptr;
        logic [1:0] cause_type;
        logic [2:0] debug_cause;
        logic [5:0] exception_cause;
        logic       debug;
        logic       exception;
        logic       trap;
    } rvfi_trap_t;

    typedef struct packed {
        logic [10:0] cause;
        logic        interrupt;
        logic        exception;
        logic        intr;
    } rvfi_intr_t;

    typedef struct packed {
        logic [31:0] order;
        logic [31:0] pc;
        logic [31:0] insn;
        logic [1:0]  mode;
        logic [2:0]  dbg;
        rvfi_trap_t  trap;
        rvfi_intr_t  intr;
    } rvfi_trace_rec_t;

    localparam logic [7:0]  TRACE_SYNC   = 8'hA5;
    localparam int unsigned TRACE_WORDS  = 5;
    localparam int unsigned TRACE_DROP_W = 8;

endpackage

// File: rtl/cv32e40s_rvfi_trace_serializer_if.sv
// Valid/ready trace word port plus the record-drop pulse.
interface cv32e40s_rvfi_trace_serializer_if;

    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic        trace_drop_o;

    modport master (
        output trace_valid_o,
        output trace_data_o,
        output trace_last_o,
        output trace_drop_o,
        input  trace_ready_i
    );

    modport slave (
        input  trace_valid_o,
        input  trace_data_o,
        input  trace_last_o,
        input  trace_drop_o,
        output trace_ready_i
    );

endinterface

// File: rtl/cv32e40s_rvfi_trace_fifo.sv
// Record FIFO for the trace serializer; pointers carry one extra wrap bit so
// full and empty are distinguishable without a counter.
module cv32e40s_rvfi_trace_fifo
    import cv32e40s_rvfi_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  rvfi_trace_rec_t wdata,
    output rvfi_trace_rec_t rdata,
    output logic            full,
    output logic            empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    rvfi_trace_rec_t mem [DEPTH];
    logic [AW:0]     wptr_q;
    logic [AW:0]     rptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rptr_q[AW-1:0]];
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

endmodule

// File: rtl/cv32e40s_rvfi_trace_serializer.sv
// Captures RVFI retirement records into a FIFO and streams each one as a
// 5-word trace frame; records arriving while full are dropped and counted.
module cv32e40s_rvfi_trace_serializer
    import cv32e40s_rvfi_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rvfi_valid_i,
    input  logic [63:0] rvfi_order_i,
    input  logic [31:0] rvfi_pc_rdata_i,
    input  logic [31:0] rvfi_insn_i,
    input  logic [1:0]  rvfi_mode_i,
    input  logic [2:0]  rvfi_dbg_i,
    input  rvfi_trap_t  rvfi_trap_i,
    input  rvfi_intr_t  rvfi_intr_i,
    cv32e40s_rvfi_trace_serializer_if.master trace
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]              state_q;
    logic [2:0]              word_idx_q;
    rvfi_trace_rec_t         frame_q;
    logic [TRACE_DROP_W-1:0] snap_q;
    logic [TRACE_DROP_W-1:0] drop_cnt_q;

    rvfi_trace_rec_t rec_in;
    rvfi_trace_rec_t fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            drop;
    logic            hs;
    logic            frame_done;
    logic [31:0]     word;
    logic            unused_order_hi;

    assign unused_order_hi = ^rvfi_order_i[63:32];

    assign rec_in = '{
        order: rvfi_order_i[31:0],
        pc:    rvfi_pc_rdata_i,
        insn:  rvfi_insn_i,
        mode:  rvfi_mode_i,
        dbg:   rvfi_dbg_i,
        trap:  rvfi_trap_i,
        intr:  rvfi_intr_i
    };

    assign hs         = (state_q == SEND) && trace.trace_ready_i;
    assign frame_done = hs && (word_idx_q == 3'(TRACE_WORDS - 1));
    // Loading on the final handshake lets a queued record follow with no bubble
    assign pop        = !fifo_empty && ((state_q == IDLE) || frame_done);
    assign drop       = rvfi_valid_i && fifo_full && !pop;
    assign push       = rvfi_valid_i && !drop;

    cv32e40s_rvfi_trace_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .wdata (rec_in),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            frame_q    <= '0;
            snap_q     <= '0;
        end else if (pop) begin
            state_q    <= SEND;
            word_idx_q <= '0;
            frame_q    <= fifo_head;
            snap_q     <= drop_cnt_q;
        end else if (frame_done) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
        end else if (hs) begin
            word_idx_q <= word_idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (pop) begin
            drop_cnt_q <= TRACE_DROP_W'(drop);
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    always_comb begin
        word = '0;
        case (word_idx_q)
            3'd0: word = {TRACE_SYNC, (snap_q != '0), frame_q.dbg, frame_q.mode,
                          frame_q.intr.intr, frame_q.trap.trap, frame_q.trap.exception,
                          frame_q.trap.debug, frame_q.trap.exception_cause, snap_q};
            3'd1: word = frame_q.order;
            3'd2: word = frame_q.pc;
            3'd3: word = frame_q.insn;
            3'd4: word = {frame_q.intr.cause, frame_q.intr.interrupt, frame_q.intr.exception,
                          frame_q.trap.debug_cause, frame_q.trap.cause_type,
                          frame_q.trap.clicptr, 13'b0};
            default: word = '0;
        endcase
    end

    assign trace.trace_valid_o = (state_q == SEND);
    assign trace.trace_data_o  = (state_q == SEND) ? word : '0;
    assign trace.trace_last_o  = (state_q == SEND) && (word_idx_q == 3'(TRACE_WORDS - 1));
    assign trace.trace_drop_o  = drop;

endmodule

// File: tb/tb_cv32e40s_rvfi_trace_serializer.sv
// Randomized bench for the RVFI trace serializer against a queue-based
// transaction model of record capture, drop accounting and frame emission.
module tb_cv32e40s_rvfi_trace_serializer;
    import cv32e40s_rvfi_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rvfi_valid = 1'b0;
    logic [63:0] rvfi_order = '0;
    logic [31:0] rvfi_pc = '0;
    logic [31:0] rvfi_insn = '0;
    logic [1:0]  rvfi_mode = '0;
    logic [2:0]  rvfi_dbg = '0;
    rvfi_trap_t  rvfi_trap = '0;
    rvfi_intr_t  rvfi_intr = '0;

    cv32e40s_rvfi_trace_serializer_if tif();

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk = ~clk;

    cv32e40s_rvfi_trace_serializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .rvfi_valid_i    (rvfi_valid),
        .rvfi_order_i    (rvfi_order),
        .rvfi_pc_rdata_i (rvfi_pc),
        .rvfi_insn_i     (rvfi_insn),
        .rvfi_mode_i     (rvfi_mode),
        .rvfi_dbg_i      (rvfi_dbg),
        .rvfi_trap_i     (rvfi_trap),
        .rvfi_intr_i     (rvfi_intr),
        .trace           (tif.master)
    );

    // Reference model: records waiting to be framed, the frame on the wire,
    // and the number of records lost since the last frame was started.
    rvfi_trace_rec_t m_q[$];
    bit              m_busy;
    int              m_idx;
    rvfi_trace_rec_t m_rec;
    int              m_snap;
    int              m_cnt;

    logic        obs_valid, obs_last, obs_drop, obs_ready;
    logic [31:0] obs_data;
    logic [34:0] obs_vec, exp_vec;

    function automatic logic [31:0] frame_word(rvfi_trace_rec_t r, int snap, int idx);
        logic [7:0] s;
        s = snap[7:0];
        case (idx)
            0: return {8'hA5, (s != 8'd0), r.dbg, r.mode, r.intr.intr, r.trap.trap,
                       r.trap.exception, r.trap.debug, r.trap.exception_cause, s};
            1: return r.order;
            2: return r.pc;
            3: return r.insn;
            default: return {r.intr.cause, r.intr.interrupt, r.intr.exception,
                             r.trap.debug_cause, r.trap.cause_type, r.trap.clicptr, 13'b0};
        endcase
    endfunction

    function automatic rvfi_trace_rec_t cur_rec();
        rvfi_trace_rec_t r;
        r.order = rvfi_order[31:0];
        r.pc    = rvfi_pc;
        r.insn  = rvfi_insn;
        r.mode  = rvfi_mode;
        r.dbg   = rvfi_dbg;
        r.trap  = rvfi_trap;
        r.intr  = rvfi_intr;
        return r;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_busy = 1'b0;
        m_idx  = 0;
        m_snap = 0;
        m_cnt  = 0;
    endfunction

    task automatic rand_fields();
        rvfi_order = {$urandom, $urandom};
        rvfi_pc    = $urandom;
        rvfi_insn  = $urandom;
        rvfi_mode  = 2'($urandom);
        rvfi_dbg   = 3'($urandom);
        rvfi_trap  = rvfi_trap_t'(15'($urandom));
        rvfi_intr  = rvfi_intr_t'(14'($urandom));
    endtask

    // Samples the DUT mid-cycle, forms the model's expectation, then advances
    // the model across the next rising edge.
    task automatic cycle();
        bit hs, pop, drop;
        @(negedge clk);
        obs_valid = tif.trace_valid_o;
        obs_last  = tif.trace_last_o;
        obs_drop  = tif.trace_drop_o;
        obs_data  = tif.trace_data_o;
        obs_ready = tif.trace_ready_i;
        hs   = m_busy && obs_ready;
        pop  = (m_q.size() != 0) && (!m_busy || (hs && m_idx == 4));
        drop = rvfi_valid && (m_q.size() == DEPTH) && !pop;
        obs_vec = {obs_valid, obs_last, obs_drop, obs_valid ? obs_data : 32'h0};
        exp_vec = {m_busy, m_busy && (m_idx == 4), drop,
                   m_busy ? frame_word(m_rec, m_snap, m_idx) : 32'h0};
        @(posedge clk);
        if (pop) begin
            m_rec  = m_q.pop_front();
            m_snap = m_cnt;
            m_cnt  = drop ? 1 : 0;
            m_busy = 1'b1;
            m_idx  = 0;
        end else begin
            if (hs) begin
                if (m_idx == 4) m_busy = 1'b0;
                else m_idx++;
            end
            if (drop && m_cnt < 255) m_cnt++;
        end
        if (rvfi_valid && !drop) m_q.push_back(cur_rec());
        #1;
    endtask

    task automatic test_reset();
        logic [34:0] v;
        rst = 1'b1;
        tif.trace_ready_i = 1'b1;
        @(negedge clk);
        v = {tif.trace_valid_o, tif.trace_last_o, tif.trace_drop_o, tif.trace_data_o};
        n_checks++;
        if (v !== 35'h0) $display("FAIL reset_outputs got=%h want=0", v);
        else n_pass++;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int first = -1;
        int last_c = -1;
        logic [31:0] w[5];
        tif.trace_ready_i = 1'b1;
        rand_fields();
        rvfi_order = {32'($urandom), 32'd7};
        rvfi_pc    = 32'h0000_0100;
        rvfi_insn  = 32'h0010_0093;
        rvfi_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            cycle();
            rvfi_valid = 1'b0;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL single_c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else n_pass++;
            if (obs_valid) begin
                if (first < 0) first = c;
                if (c - first < 5) w[c - first] = obs_data;
            end
            if (obs_last) last_c = c;
        end
        n_checks++;
        if (first != 2 || last_c != 6) $display("FAIL single_latency got=%0d..%0d want=2..6", first, last_c);
        else n_pass++;
        n_checks++;
        if ({w[0][31:23], w[0][7:0]} !== {8'hA5, 1'b0, 8'h00} || w[1] !== 32'h7 ||
            w[2] !== 32'h100 || w[3] !== 32'h0010_0093)
            $display("FAIL single_words got=%h %h %h %h want=A5..00 7 100 00100093", w[0], w[1], w[2], w[3]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int nvalid = 0, first = -1, lastv = -1, wc = 0, fr = 0;
        logic [31:0] ord[3];
        tif.trace_ready_i = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c < 3) begin
                rand_fields();
                rvfi_order = 64'(c);
                rvfi_valid = 1'b1;
            end else begin
                rvfi_valid = 1'b0;
            end
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL b2b_c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else n_pass++;
            if (obs_valid) begin
                nvalid++;
                if (first < 0) first = c;
                lastv = c;
                if (wc == 1 && fr < 3) ord[fr] = obs_data;
                if (wc == 4) fr++;
                wc = (wc + 1) % 5;
            end
        end
        n_checks++;
        if (nvalid != 15 || lastv - first != 14)
            $display("FAIL b2b_contiguous got=%0d words span %0d want=15 span 14", nvalid, lastv - first);
        else n_pass++;
        n_checks++;
        if (ord[0] !== 32'd0 || ord[1] !== 32'd1 || ord[2] !== 32'd2)
            $display("FAIL b2b_orders got=%0d %0d %0d want=0 1 2", ord[0], ord[1], ord[2]);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bit hold = 1'b0;
        logic [32:0] held;
        for (int c = 0; c < 400; c++) begin
            rand_fields();
            rvfi_valid = ($urandom_range(0, 2) == 0);
            tif.trace_ready_i = $urandom_range(0, 1);
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL bp_c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else n_pass++;
            if (hold) begin
                n_checks++;
                if ({obs_valid, obs_last, obs_data} !== {1'b1, held})
                    $display("FAIL bp_stable_c%0d got=%b/%h want=1/%h", c, obs_valid, {obs_last, obs_data}, held);
                else n_pass++;
            end
            hold = obs_valid && !obs_ready;
            held = {obs_last, obs_data};
        end
        rvfi_valid = 1'b0;
        tif.trace_ready_i = 1'b1;
        for (int c = 0; c < 60 && (m_busy || m_q.size() != 0); c++) begin
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL bp_drain_c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else n_pass++;
        end
        cycle();
        n_checks++;
        if (obs_valid !== 1'b0) $display("FAIL bp_drained got=%b want=0", obs_valid);
        else n_pass++;
    endtask

    // Fills the frame register and FIFO with ready low, then drains and
    // returns the header of each emitted frame.
    task automatic run_overflow(input int pushes, input string tag,
                                output int drops, output int frames, output logic [31:0] hdr[8]);
        int wc = 0;
        drops = 0;
        frames = 0;
        tif.trace_ready_i = 1'b0;
        for (int c = 0; c < pushes; c++) begin
            rand_fields();
            rvfi_valid = 1'b1;
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL %s_fill_c%0d got=%h want=%h", tag, c, obs_vec, exp_vec);
            else n_pass++;
            if (obs_drop) drops++;
        end
        rvfi_valid = 1'b0;
        tif.trace_ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL %s_drain_c%0d got=%h want=%h", tag, c, obs_vec, exp_vec);
            else n_pass++;
            if (obs_valid) begin
                if (wc == 0 && frames < 8) hdr[frames] = obs_data;
                if (wc == 4) frames++;
                wc = (wc + 1) % 5;
            end
        end
    endtask

    task automatic test_overflow();
        int drops, frames;
        logic [31:0] hdr[8];
        run_overflow(8, "ovf", drops, frames, hdr);
        n_checks++;
        if (drops != 3 || frames != 5) $display("FAIL ovf_counts got=%0d drops %0d frames want=3 drops 5 frames", drops, frames);
        else n_pass++;
        n_checks++;
        if ({hdr[1][23], hdr[1][7:0]} !== 9'h103 || {hdr[2][23], hdr[2][7:0]} !== 9'h000)
            $display("FAIL ovf_snap got=%h %h want=ovf1 snap03, ovf0 snap00", hdr[1], hdr[2]);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int drops, frames;
        logic [31:0] hdr[8];
        run_overflow(310, "sat", drops, frames, hdr);
        n_checks++;
        if (drops != 305) $display("FAIL sat_drops got=%0d want=305", drops);
        else n_pass++;
        n_checks++;
        if ({hdr[1][31:23], hdr[1][7:0]} !== {8'hA5, 1'b1, 8'hFF})
            $display("FAIL sat_snap got=%h want=A5 ovf1 snapFF", hdr[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int wc = 0;
        int first = -1;
        bit hit = 1'b0;
        logic [31:0] w0 = '0;
        tif.trace_ready_i = 1'b1;
        rand_fields();
        rvfi_valid = 1'b1;
        for (int c = 0; c < 12 && !hit; c++) begin
            cycle();
            rvfi_valid = 1'b0;
            if (obs_valid && obs_ready) begin
                if (wc == 2) hit = 1'b1;
                wc++;
            end
        end
        n_checks++;
        if (!hit) $display("FAIL rmf_word2 got=timeout want=word2 handshake");
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({tif.trace_valid_o, tif.trace_last_o} !== 2'b00)
            $display("FAIL rmf_async got=%b want=00", {tif.trace_valid_o, tif.trace_last_o});
        else n_pass++;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rand_fields();
        rvfi_valid = 1'b1;
        for (int c = 0; c < 9; c++) begin
            cycle();
            rvfi_valid = 1'b0;
            n_checks++;
            if (obs_vec !== exp_vec) $display("FAIL rmf_c%0d got=%h want=%h", c, obs_vec, exp_vec);
            else n_pass++;
            if (obs_valid && first < 0) begin
                first = c;
                w0 = obs_data;
            end
        end
        n_checks++;
        if (first != 2 || {w0[31:23], w0[7:0]} !== {8'hA5, 1'b0, 8'h00})
            $display("FAIL rmf_restart got=c%0d %h want=c2 A5 ovf0 snap00", first, w0);
        else n_pass++;
    endtask

    initial begin
        tif.trace_ready_i = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_saturation();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=bench completion");
        $fatal(1);
    end

endmodule
